// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction ROM port, decode handshake and control from execute.
interface fetch_if #(
  parameter int unsigned PC_W = 16
);
  localparam int unsigned INSTR_W = 16;

  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               halt;

  // Fetch unit side
  modport master (
    output imem_en, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, instr_ready, redirect, redirect_pc, halt
  );

  // Environment side: ROM, decode and execute
  modport slave (
    input  imem_en, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, instr_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the synchronous ROM, buffers words in a
// small prefetch FIFO and presents {instr, instr_pc} to decode. Redirects flush
// the FIFO and toggle an epoch bit so the stale ROM response is dropped.
module fetch_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     QDEPTH   = 2
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(QDEPTH + 1);
  localparam int unsigned OCC_W   = CNT_W + 1;
  localparam logic [OCC_W-1:0] QDEPTH_OCC = OCC_W'(QDEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } q_entry_t;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  q_entry_t         mem_q [QDEPTH];
  q_entry_t         mem_d [QDEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_epoch_q, inflight_epoch_d;
  logic             epoch_q, epoch_d;

  logic             q_valid;
  logic             pop;
  logic             push;
  logic             issue;
  logic [OCC_W-1:0] occ;

  // Handshake and issue decisions for this cycle
  always_comb begin
    q_valid = (count_q != '0);
    pop     = q_valid & bus.instr_ready;
    push    = inflight_q & (inflight_epoch_q == epoch_q) & ~bus.redirect;
    // Occupancy after this cycle's pop, counting the read already in flight
    occ     = {1'b0, count_q} + OCC_W'(inflight_q) - OCC_W'(pop);
    issue   = ~rst & ~bus.redirect & ~bus.halt & (occ < QDEPTH_OCC);
  end

  // Next-state: issue, FIFO push/pop, redirect flush
  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    mem_d            = mem_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    inflight_d       = 1'b0;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;
    epoch_d          = epoch_q;

    if (issue) begin
      inflight_d       = 1'b1;
      inflight_pc_d    = fetch_pc_q;
      inflight_epoch_d = epoch_q;
      fetch_pc_d       = fetch_pc_q + PC_W'(1);
    end

    if (bus.redirect) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      epoch_d    = ~epoch_q;
      fetch_pc_d = bus.redirect_pc;
    end else begin
      if (push) begin
        mem_d[tail_q] = '{instr: bus.imem_rdata, pc: inflight_pc_q};
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q       <= RESET_PC;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // ROM strobe and decode-facing outputs
  assign bus.imem_en     = issue;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = q_valid;
  assign bus.instr       = mem_q[head_q].instr;
  assign bus.instr_pc    = mem_q[head_q].pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run. The
// expected program-order stream is queued by the stimulus process and consumed
// by a negedge monitor on every accepted instruction.
module tb_fetch_unit;

  localparam int unsigned PC_W     = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic clk;
  logic rst;

  fetch_if #(.PC_W(PC_W)) bus ();

  fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC), .QDEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_next     = '0;
  int          pop_count   = 0;
  logic [15:0] last_pop_pc = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  // Synchronous ROM; junk on the bus when not read so stray pushes show up
  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_en ? rom_word(bus.imem_addr) : 16'hBAD0;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_top_up();
    while (exp_q.size() < 16) begin
      exp_q.push_back(sb_next);
      sb_next = sb_next + 16'd1;
    end
  endtask

  // New program-order stream starting at pc
  task automatic sb_reload(input logic [15:0] pc);
    exp_q.delete();
    sb_next = pc;
    sb_top_up();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_top_up();
  endtask

  // Monitor: scoreboard pops, hold stability, issue-rule and address-sequence checks
  logic        prev_hold    = 1'b0;
  logic [15:0] prev_instr   = '0;
  logic [15:0] prev_pc      = '0;
  logic [15:0] exp_fetch_pc = '0;

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      chk("imem_en_in_reset", 16'(bus.imem_en), 16'd0);
    end else begin
      if (bus.redirect || bus.halt)
        chk("imem_en_blocked", 16'(bus.imem_en), 16'd0);
      else if (!bus.instr_valid || bus.instr_ready)
        chk("imem_en_live", 16'(bus.imem_en), 16'd1);
      if (bus.imem_en)
        chk("imem_addr_seq", bus.imem_addr, exp_fetch_pc);
      if (prev_hold) begin
        chk("hold_valid", 16'(bus.instr_valid), 16'd1);
        chk("hold_instr", bus.instr, prev_instr);
        chk("hold_pc", bus.instr_pc, prev_pc);
      end
      if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: got pc %h expected none at %0t", bus.instr_pc, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", bus.instr_pc, e);
          chk("sb_instr", bus.instr, rom_word(e));
        end
        pop_count++;
        last_pop_pc = bus.instr_pc;
      end
    end
    prev_hold  = !rst && !bus.redirect && bus.instr_valid && !bus.instr_ready;
    prev_instr = bus.instr;
    prev_pc    = bus.instr_pc;
    if (rst)               exp_fetch_pc = RESET_PC;
    else if (bus.redirect) exp_fetch_pc = bus.redirect_pc;
    else if (bus.imem_en)  exp_fetch_pc = exp_fetch_pc + 16'd1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish at %0t", $time);
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    logic [15:0] hold_pc;
    logic [15:0] hold_instr;
    logic        found;
    int          base;
    int          r;

    rst             = 1'b1;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt        = 1'b0;
    sb_reload(RESET_PC);

    // Reset state
    repeat (3) tick();
    #1;
    chk("rst_valid", 16'(bus.instr_valid), 16'd0);
    chk("rst_instr", bus.instr, 16'd0);
    chk("rst_instr_pc", bus.instr_pc, 16'd0);
    chk("rst_imem_en", 16'(bus.imem_en), 16'd0);

    // Release: first request immediately, first valid on the third cycle
    tick();
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    #1;
    chk("c1_valid", 16'(bus.instr_valid), 16'd0);
    chk("c1_imem_en", 16'(bus.imem_en), 16'd1);
    chk("c1_addr", bus.imem_addr, 16'h0000);
    tick(); #1;
    chk("c2_valid", 16'(bus.instr_valid), 16'd0);
    chk("c2_addr", bus.imem_addr, 16'h0001);
    tick(); #1;
    chk("c3_valid", 16'(bus.instr_valid), 16'd1);
    chk("c3_pc", bus.instr_pc, 16'h0000);
    chk("c3_instr", bus.instr, 16'hA000);

    // Stream at full rate until pc 5 is at the head
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(); #1;
      chk("throughput_valid", 16'(bus.instr_valid), 16'd1);
      if (bus.instr_valid && bus.instr_pc == 16'h0005) found = 1'b1;
    end
    chk("reach_pc5", 16'(found), 16'd1);

    // Redirect to 0x0040 while pc 6 is in flight
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    sb_reload(16'h0040);
    #1;
    chk("redir_no_issue", 16'(bus.imem_en), 16'd0);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("redir1_valid", 16'(bus.instr_valid), 16'd0);
    chk("redir1_imem_en", 16'(bus.imem_en), 16'd1);
    chk("redir1_addr", bus.imem_addr, 16'h0040);
    tick(); #1;
    chk("redir2_valid", 16'(bus.instr_valid), 16'd0);
    tick(); #1;
    chk("redir3_valid", 16'(bus.instr_valid), 16'd1);
    chk("redir3_pc", bus.instr_pc, 16'h0040);
    chk("redir3_instr", bus.instr, rom_word(16'h0040));

    // Backpressure for 5 cycles
    repeat (3) tick();
    bus.instr_ready = 1'b0;
    #1;
    hold_pc    = bus.instr_pc;
    hold_instr = bus.instr;
    chk("bp_valid", 16'(bus.instr_valid), 16'd1);
    chk("bp_stop_issue", 16'(bus.imem_en), 16'd0);
    repeat (4) begin
      tick(); #1;
      chk("bp_pc_stable", bus.instr_pc, hold_pc);
      chk("bp_instr_stable", bus.instr, hold_instr);
      chk("bp_no_issue", 16'(bus.imem_en), 16'd0);
    end
    tick();
    bus.instr_ready = 1'b1;
    repeat (4) tick();

    // Wrap: FFFE, FFFF, 0000, 0001
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    sb_reload(16'hFFFE);
    base = pop_count;
    tick();
    bus.redirect = 1'b0;
    repeat (6) tick();
    chk("wrap_pops", 16'(pop_count - base >= 4), 16'd1);
    chk("wrap_last_pc", last_pop_pc, 16'h0001);

    // Halt for 4 cycles with decode ready
    repeat (3) tick();
    bus.halt = 1'b1;
    #1;
    chk("halt_no_issue", 16'(bus.imem_en), 16'd0);
    repeat (3) begin
      tick(); #1;
      chk("halt_no_issue", 16'(bus.imem_en), 16'd0);
    end
    chk("halt_drained", 16'(bus.instr_valid), 16'd0);
    tick();
    bus.halt = 1'b0;
    #1;
    chk("halt_resume_en", 16'(bus.imem_en), 16'd1);
    chk("halt_resume_addr", bus.imem_addr, last_pop_pc + 16'd1);

    // One-cycle reset with occupied queue and a read in flight
    repeat (3) tick();
    bus.instr_ready = 1'b0;
    rst = 1'b1;
    sb_reload(RESET_PC);
    tick();
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    #1;
    chk("rst2_valid", 16'(bus.instr_valid), 16'd0);
    chk("rst2_instr", bus.instr, 16'd0);
    chk("rst2_addr", bus.imem_addr, RESET_PC);
    chk("rst2_imem_en", 16'(bus.imem_en), 16'd1);
    tick(); #1;
    chk("rst2_c2_valid", 16'(bus.instr_valid), 16'd0);
    tick(); #1;
    chk("rst2_c3_valid", 16'(bus.instr_valid), 16'd1);
    chk("rst2_c3_pc", bus.instr_pc, RESET_PC);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      r = int'($urandom_range(0, 99));
      rst          = (r == 0);
      bus.redirect = (r >= 1 && r <= 4);
      if (rst) begin
        sb_reload(RESET_PC);
      end else if (bus.redirect) begin
        if ($urandom_range(0, 3) == 0)
          bus.redirect_pc = 16'hFFF0 + 16'($urandom_range(0, 15));
        else
          bus.redirect_pc = 16'($urandom_range(0, 255));
        sb_reload(bus.redirect_pc);
      end
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      bus.halt        = ($urandom_range(0, 9) == 0);
    end

    tick();
    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.halt        = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
